// File: rtl/prime_spi_driver.sv
// Host-side SPI front end for the prime detector: serializes a parallel candidate
// MSB-first, toggles the detector ready level, then returns is_prime or a timeout.
module prime_spi_driver #(
    parameter int nbits          = 16,
    parameter int half_period    = 2,
    parameter int timeout_cycles = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] opa,
    input  logic             istream_val,
    output logic             istream_rdy,
    output logic             sdi,
    output logic             sclk,
    output logic             cs_n,
    output logic             ready_tgl,
    input  logic             done,
    input  logic             is_prime,
    output logic             result_prime,
    output logic             result_timeout,
    output logic             ostream_val,
    input  logic             ostream_rdy
);

    localparam int BCW = $clog2(nbits + 1);
    localparam int HCW = (half_period > 1) ? $clog2(half_period) : 1;
    localparam int TCW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

    localparam logic [BCW-1:0] BIT_INIT = BCW'(nbits);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [HCW-1:0] HP_LAST  = HCW'(half_period - 1);
    localparam logic [HCW-1:0] HP_ONE   = HCW'(1);
    localparam logic [HCW-1:0] HP_ZERO  = {HCW{1'b0}};
    localparam logic [TCW-1:0] TMO_LAST = TCW'(timeout_cycles - 1);
    localparam logic [TCW-1:0] TMO_ONE  = TCW'(1);
    localparam logic [TCW-1:0] TMO_ZERO = {TCW{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_NOTIFY = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [nbits-1:0] shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [HCW-1:0]   ph_cnt_q, ph_cnt_d;
    logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic             sdi_q, sdi_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             ready_tgl_q, ready_tgl_d;
    logic             done_q, done_d;
    logic             result_prime_q, result_prime_d;
    logic             result_timeout_q, result_timeout_d;
    logic             ostream_val_q, ostream_val_d;
    logic             istream_rdy_q, istream_rdy_d;
    logic [nbits-1:0] shift_nxt_s;

    assign shift_nxt_s = shift_q << 1;

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d          = state_q;
        shift_d          = shift_q;
        bit_cnt_d        = bit_cnt_q;
        ph_cnt_d         = ph_cnt_q;
        tmo_cnt_d        = tmo_cnt_q;
        sdi_d            = sdi_q;
        sclk_d           = sclk_q;
        cs_n_d           = cs_n_q;
        ready_tgl_d      = ready_tgl_q;
        done_d           = done;
        result_prime_d   = result_prime_q;
        result_timeout_d = result_timeout_q;
        ostream_val_d    = ostream_val_q;
        istream_rdy_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (istream_val && istream_rdy_q) begin
                    shift_d   = opa;
                    bit_cnt_d = BIT_INIT;
                    ph_cnt_d  = HP_ZERO;
                    sdi_d     = opa[nbits-1];
                    sclk_d    = 1'b0;
                    cs_n_d    = 1'b0;
                    state_d   = S_SHIFT;
                end else begin
                    istream_rdy_d = 1'b1;
                end
            end
            S_SHIFT: begin
                // A bit ends after its high phase; the final one closes the frame.
                if (ph_cnt_q == HP_LAST) begin
                    ph_cnt_d = HP_ZERO;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        shift_d   = shift_nxt_s;
                        bit_cnt_d = bit_cnt_q - BIT_ONE;
                        if (bit_cnt_q == BIT_ONE) begin
                            cs_n_d      = 1'b1;
                            sdi_d       = 1'b0;
                            ready_tgl_d = ~ready_tgl_q;
                            state_d     = S_NOTIFY;
                        end else begin
                            sdi_d = shift_nxt_s[nbits-1];
                        end
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + HP_ONE;
                end
            end
            S_NOTIFY: begin
                tmo_cnt_d = TMO_ZERO;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A fresh done edge takes priority over an expiring timeout.
                if (done && !done_q) begin
                    result_prime_d   = is_prime;
                    result_timeout_d = 1'b0;
                    ostream_val_d    = 1'b1;
                    state_d          = S_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    result_prime_d   = 1'b0;
                    result_timeout_d = 1'b1;
                    ostream_val_d    = 1'b1;
                    state_d          = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
            end
            S_RESP: begin
                if (ostream_rdy) begin
                    ostream_val_d = 1'b0;
                    istream_rdy_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    ostream_val_d = 1'b1;
                end
            end
            default: begin
                sclk_d        = 1'b0;
                cs_n_d        = 1'b1;
                ostream_val_d = 1'b0;
                state_d       = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            shift_q          <= {nbits{1'b0}};
            bit_cnt_q        <= {BCW{1'b0}};
            ph_cnt_q         <= HP_ZERO;
            tmo_cnt_q        <= TMO_ZERO;
            sdi_q            <= 1'b0;
            sclk_q           <= 1'b0;
            cs_n_q           <= 1'b1;
            ready_tgl_q      <= 1'b0;
            done_q           <= 1'b0;
            result_prime_q   <= 1'b0;
            result_timeout_q <= 1'b0;
            ostream_val_q    <= 1'b0;
            istream_rdy_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            shift_q          <= shift_d;
            bit_cnt_q        <= bit_cnt_d;
            ph_cnt_q         <= ph_cnt_d;
            tmo_cnt_q        <= tmo_cnt_d;
            sdi_q            <= sdi_d;
            sclk_q           <= sclk_d;
            cs_n_q           <= cs_n_d;
            ready_tgl_q      <= ready_tgl_d;
            done_q           <= done_d;
            result_prime_q   <= result_prime_d;
            result_timeout_q <= result_timeout_d;
            ostream_val_q    <= ostream_val_d;
            istream_rdy_q    <= istream_rdy_d;
        end
    end

    assign istream_rdy    = istream_rdy_q;
    assign sdi            = sdi_q;
    assign sclk           = sclk_q;
    assign cs_n           = cs_n_q;
    assign ready_tgl      = ready_tgl_q;
    assign result_prime   = result_prime_q;
    assign result_timeout = result_timeout_q;
    assign ostream_val    = ostream_val_q;

endmodule

// File: tb/tb_prime_spi_driver.sv
// Directed bench for prime_spi_driver: a detector model and scoreboard queues
// hold the expected serial frames and results.
module tb_prime_spi_driver;

    localparam int NB  = 16;
    localparam int HP  = 2;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] opa;
    logic          istream_val;
    logic          istream_rdy;
    logic          sdi, sclk, cs_n, ready_tgl;
    logic          done = 1'b0;
    logic          is_prime = 1'b0;
    logic          result_prime, result_timeout, ostream_val;
    logic          ostream_rdy;

    prime_spi_driver #(.nbits(NB), .half_period(HP), .timeout_cycles(TMO)) dut (
        .clk(clk), .reset(reset), .opa(opa), .istream_val(istream_val),
        .istream_rdy(istream_rdy), .sdi(sdi), .sclk(sclk), .cs_n(cs_n),
        .ready_tgl(ready_tgl), .done(done), .is_prime(is_prime),
        .result_prime(result_prime), .result_timeout(result_timeout),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit prime_f(input logic [NB-1:0] v);
        int n = int'(v);
        if (n < 2) return 1'b0;
        for (int i = 2; i * i <= n; i++) begin
            if (n % i == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    logic [NB-1:0] exp_opa_q[$];
    logic [1:0]    exp_res_q[$];   // {timeout, prime}

    int            det_mode  = 0;  // 0 responds, 1 done stays low, 2 done stuck high
    int            det_delay = 3;
    int            det_cnt   = -1;
    logic          done_m    = 1'b0;
    logic          tgl_seen  = 1'b0;
    logic          tgl_exp   = 1'b0;
    logic          sclk_p    = 1'b0;
    logic          cs_n_p    = 1'b1;
    logic          val_p     = 1'b0;
    logic [NB-1:0] cap       = '0;
    logic [NB-1:0] frame_exp = '0;
    logic [NB-1:0] frame_val = '0;
    logic [1:0]    res_e;
    int            nbit = 0;
    int            cs_low = 0;
    int            cs_rise_cyc = 0;
    int            val_rise_cyc = 0;

    // Frame monitor, detector model and output scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            sclk_p = 1'b0; cs_n_p = 1'b1; val_p = 1'b0;
            tgl_seen = 1'b0; tgl_exp = 1'b0; det_cnt = -1; done_m = 1'b0;
            done = 1'b0; is_prime = 1'b0; nbit = 0; cs_low = 0; cap = '0;
        end else begin
            if (cs_n_p && !cs_n) begin
                frame_exp = (exp_opa_q.size() > 0) ? exp_opa_q[0] : 16'hxxxx;
                nbit = 0; cap = '0; cs_low = 0;
            end
            if (!cs_n) begin
                cs_low++;
                if (sclk) begin
                    if (!sclk_p) begin
                        nbit++;
                        cap = {cap[NB-2:0], sdi};
                    end
                    if (nbit >= 1 && nbit <= NB) chk("sdi_bit", sdi, frame_exp[NB-nbit]);
                end
            end
            if (!cs_n_p && cs_n) begin
                chk("frame_bits", nbit, NB);
                chk("frame_data", cap, frame_exp);
                chk("cs_low_cycles", cs_low, 2 * HP * NB);
                if (exp_opa_q.size() > 0) void'(exp_opa_q.pop_front());
                frame_val = cap;
                cs_rise_cyc = cyc;
                tgl_exp = ~tgl_exp;
                chk("ready_tgl", ready_tgl, tgl_exp);
            end
            if (ready_tgl !== tgl_seen) begin
                tgl_seen = ready_tgl; done_m = 1'b0; det_cnt = det_delay;
            end else if (det_cnt > 0) begin
                det_cnt--;
            end else if (det_cnt == 0) begin
                done_m = 1'b1; is_prime = prime_f(frame_val); det_cnt = -1;
            end
            done = (det_mode == 2) ? 1'b1 : (det_mode == 1) ? 1'b0 : done_m;
            if (ostream_val && !val_p) val_rise_cyc = cyc;
            if (ostream_val && ostream_rdy) begin
                chk("res_avail", exp_res_q.size() > 0, 1);
                if (exp_res_q.size() > 0) begin
                    res_e = exp_res_q.pop_front();
                    chk("result_prime", result_prime, res_e[0]);
                    chk("result_timeout", result_timeout, res_e[1]);
                end
            end
            sclk_p = sclk; cs_n_p = cs_n; val_p = ostream_val;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NB-1:0] v);
        int n = 0;
        while (istream_rdy !== 1'b1 && n < 500) begin step(); n++; end
        chk("istream_rdy_wait", istream_rdy, 1'b1);
        opa = v; istream_val = 1'b1;
        step();
        istream_val = 1'b0; opa = '0;
        exp_opa_q.push_back(v);
        exp_res_q.push_back((det_mode == 0) ? {1'b0, prime_f(v)} : 2'b10);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_res_q.size() != 0 && n < budget) begin step(); n++; end
        chk("result_drained", exp_res_q.size(), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; istream_val = 1'b0; opa = '0; ostream_rdy = 1'b1;
        repeat (3) step();
        chk("rst_istream_rdy", istream_rdy, 0);
        chk("rst_sdi", sdi, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_ready_tgl", ready_tgl, 0);
        chk("rst_result_prime", result_prime, 0);
        chk("rst_result_timeout", result_timeout, 0);
        chk("rst_ostream_val", ostream_val, 0);
        reset = 1'b0;
        step(); step();
        chk("idle_rdy", istream_rdy, 1);

        send(16'd17); drain(400);
        send(16'd15); drain(400);

        ostream_rdy = 1'b0;
        send(16'hFFFF);
        n = 0;
        while (ostream_val !== 1'b1 && n < 400) begin step(); n++; end
        chk("bp_val_rise", ostream_val, 1);
        repeat (10) begin
            step();
            chk("bp_val_hold", ostream_val, 1);
            chk("bp_prime_hold", result_prime, exp_res_q[0][0]);
            chk("bp_timeout_hold", result_timeout, exp_res_q[0][1]);
            chk("bp_istream_rdy", istream_rdy, 0);
        end
        ostream_rdy = 1'b1;
        step();
        chk("bp_idle_rdy", istream_rdy, 1);
        chk("bp_val_low", ostream_val, 0);
        send(16'd2); drain(400);
        chk("tgl_back_to_zero", ready_tgl, 0);

        det_mode = 1;
        send(16'd11); drain(400);
        chk("tmo_low_latency", val_rise_cyc - cs_rise_cyc, TMO + 1);

        det_mode = 2;
        step();
        send(16'd13); drain(400);
        chk("tmo_stuck_latency", val_rise_cyc - cs_rise_cyc, TMO + 1);
        det_mode = 0;

        det_delay = 20;
        send(16'd53);
        repeat (10) step();
        istream_val = 1'b1; opa = 16'hAAAA;
        repeat (3) step();
        istream_val = 1'b0;
        n = 0;
        while (cs_n !== 1'b1 && n < 200) begin step(); n++; end
        chk("ign_frame_end", cs_n, 1);
        istream_val = 1'b1; opa = 16'h5555;
        repeat (5) step();
        istream_val = 1'b0; opa = '0;
        drain(400);
        det_delay = 3;

        send(16'h1234);
        n = 0;
        while (nbit < 5 && n < 200) begin step(); n++; end
        chk("mid_shift_bits", nbit >= 5, 1);
        reset = 1'b1;
        #1;
        chk("mr_cs_n", cs_n, 1);
        chk("mr_sclk", sclk, 0);
        chk("mr_ready_tgl", ready_tgl, 0);
        chk("mr_istream_rdy", istream_rdy, 0);
        exp_opa_q.delete();
        exp_res_q.delete();
        repeat (3) step();
        chk("mr_hold_rdy", istream_rdy, 0);
        chk("mr_hold_val", ostream_val, 0);
        chk("mr_hold_cs_n", cs_n, 1);
        reset = 1'b0;
        repeat (2) step();
        chk("mr_release_rdy", istream_rdy, 1);
        chk("mr_release_val", ostream_val, 0);
        send(16'd7); drain(400);
        chk("final_prime", result_prime, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
